// File: rtl/ram_panel_loader.sv
// rtl/ram_panel_loader.sv - front-panel RAM programming controller
//
// Purpose:
//   Shares one synchronous single-port RAM between the CPU (run mode) and the
//   operator panel (program mode). Entering program mode asks the CPU to halt.
//   The panel owns the RAM only after the CPU acknowledges the halt. Each step
//   key press writes panel_data, or reads back the RAM, at an auto-incrementing
//   panel address.
//
// Ports:
//   clock, clear_n            system clock, async active-low reset
//   mode_prog, step,          async panel switch/keys (synchronised here)
//   addr_clear
//   write_sw, panel_data      panel R/W select and data switches
//   cpu_addr/wdata/we         CPU-side RAM request (honoured in RUN/HALTING)
//   cpu_halted / cpu_halt     halt acknowledge in, halt request out
//   ram_addr/wdata/we/rdata   RAM port (rdata valid one cycle after address)
//   panel_addr, panel_q       panel address counter and last data seen
//   prog_active               panel owns the RAM
module ram_panel_loader #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              mode_prog,
   input  logic              step,
   input  logic              addr_clear,
   input  logic              write_sw,
   input  logic [DATA_W-1:0] panel_data,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_halted,
   output logic              cpu_halt,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] panel_addr,
   output logic [DATA_W-1:0] panel_q,
   output logic              prog_active
);

   typedef enum logic [2:0] {
      S_RUN      = 3'd0,
      S_HALTING  = 3'd1,
      S_PROG     = 3'd2,
      S_WRITE    = 3'd3,
      S_READ     = 3'd4,
      S_READWAIT = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic                    cpu_halt_q, cpu_halt_d;
   logic                    prog_active_q, prog_active_d;
   logic [ADDR_W-1:0]       panel_addr_q, panel_addr_d;
   logic [DATA_W-1:0]       panel_q_q, panel_q_d;

   logic [SYNC_STAGES-1:0]  mode_sync_q, mode_sync_d;
   logic [SYNC_STAGES-1:0]  step_sync_q, step_sync_d;
   logic [SYNC_STAGES-1:0]  clr_sync_q, clr_sync_d;
   logic                    step_prev_q, step_prev_d;
   logic                    clr_prev_q, clr_prev_d;

   logic                    mode_prog_s;
   logic                    step_s;
   logic                    clr_s;
   logic                    step_pulse;
   logic                    clr_pulse;
   logic [ADDR_W-1:0]       panel_addr_inc;

   // Synchronisers shift in at bit 0; the MSB is the settled value.
   always_comb begin
      mode_sync_d = {mode_sync_q[SYNC_STAGES-2:0], mode_prog};
      step_sync_d = {step_sync_q[SYNC_STAGES-2:0], step};
      clr_sync_d  = {clr_sync_q[SYNC_STAGES-2:0], addr_clear};
   end

   assign mode_prog_s = mode_sync_q[SYNC_STAGES-1];
   assign step_s      = step_sync_q[SYNC_STAGES-1];
   assign clr_s       = clr_sync_q[SYNC_STAGES-1];

   // The edge detectors track the settled key in every state. A key held
   // through a reset or through a busy state does not later look like a fresh
   // press.
   assign step_prev_d = step_s;
   assign clr_prev_d  = clr_s;
   assign step_pulse  = step_s & ~step_prev_q;
   assign clr_pulse   = clr_s & ~clr_prev_q;

   assign panel_addr_inc = panel_addr_q + ADDR_W'(1);

   always_comb begin
      state_d       = state_q;
      cpu_halt_d    = cpu_halt_q;
      prog_active_d = prog_active_q;
      panel_addr_d  = panel_addr_q;
      panel_q_d     = panel_q_q;
      case (state_q)
         S_RUN: begin
            if (mode_prog_s) begin
               state_d    = S_HALTING;
               cpu_halt_d = 1'b1;
            end
         end
         S_HALTING: begin
            // The switch is released before the ack arrives: abandon the halt.
            if (!mode_prog_s) begin
               state_d    = S_RUN;
               cpu_halt_d = 1'b0;
            end else if (cpu_halted) begin
               state_d       = S_PROG;
               prog_active_d = 1'b1;
            end
         end
         S_PROG: begin
            if (!mode_prog_s) begin
               state_d       = S_RUN;
               cpu_halt_d    = 1'b0;
               prog_active_d = 1'b0;
            end else if (clr_pulse) begin
               // Clear takes priority; a simultaneous step is dropped.
               panel_addr_d = '0;
            end else if (step_pulse) begin
               state_d = write_sw ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            panel_q_d    = panel_data;
            panel_addr_d = panel_addr_inc;
            state_d      = S_PROG;
         end
         S_READ: begin
            state_d = S_READWAIT;
         end
         S_READWAIT: begin
            panel_q_d    = ram_rdata;
            panel_addr_d = panel_addr_inc;
            state_d      = S_PROG;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= S_RUN;
         cpu_halt_q    <= 1'b0;
         prog_active_q <= 1'b0;
         panel_addr_q  <= '0;
         panel_q_q     <= '0;
         mode_sync_q   <= '0;
         step_sync_q   <= '0;
         clr_sync_q    <= '0;
         step_prev_q   <= 1'b0;
         clr_prev_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cpu_halt_q    <= cpu_halt_d;
         prog_active_q <= prog_active_d;
         panel_addr_q  <= panel_addr_d;
         panel_q_q     <= panel_q_d;
         mode_sync_q   <= mode_sync_d;
         step_sync_q   <= step_sync_d;
         clr_sync_q    <= clr_sync_d;
         step_prev_q   <= step_prev_d;
         clr_prev_q    <= clr_prev_d;
      end
   end

   // The RAM port follows the CPU until the halt is acknowledged. It is
   // decoded from the state register, so an async reset in WRITE removes
   // ram_we at once.
   always_comb begin
      ram_addr  = panel_addr_q;
      ram_wdata = panel_data;
      ram_we    = 1'b0;
      case (state_q)
         S_RUN, S_HALTING: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
         end
         S_WRITE: begin
            ram_we = 1'b1;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

   assign cpu_halt    = cpu_halt_q;
   assign prog_active = prog_active_q;
   assign panel_addr  = panel_addr_q;
   assign panel_q     = panel_q_q;

endmodule

// File: tb/tb_ram_panel_loader.sv
// tb/tb_ram_panel_loader.sv - testbench for ram_panel_loader
module tb_ram_panel_loader;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              clear_n;
   logic              mode_prog, step, addr_clear, write_sw;
   logic [DATA_W-1:0] panel_data;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we, cpu_halted;
   logic              cpu_halt;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic [ADDR_W-1:0] panel_addr;
   logic [DATA_W-1:0] panel_q;
   logic              prog_active;

   ram_panel_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
      .clock(clock), .clear_n(clear_n), .mode_prog(mode_prog), .step(step),
      .addr_clear(addr_clear), .write_sw(write_sw), .panel_data(panel_data),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_halted(cpu_halted), .cpu_halt(cpu_halt), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .panel_addr(panel_addr), .panel_q(panel_q), .prog_active(prog_active)
   );

   always #5 clock = ~clock;

   // Synchronous single-port RAM attached to the DUT
   logic [DATA_W-1:0] ram [DEPTH];
   int                wr_count = 0;
   initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
   always @(posedge clock) begin
      if (ram_we) begin
         ram[ram_addr] <= ram_wdata;
         wr_count      = wr_count + 1;
      end
      ram_rdata <= ram[ram_addr];
   end

   // Reference model of the panel's view of memory
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_addr;
   logic [DATA_W-1:0] m_q;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic s, input logic c);
      step = s;
      addr_clear = c;
      repeat (6) cyc();
      step = 1'b0;
      addr_clear = 1'b0;
      repeat (4) cyc();
   endtask

   // kind: 0 write, 1 read, 2 clear, 3 step+clear together
   task automatic op(input int kind, input logic [DATA_W-1:0] d);
      int w0;
      int exp_w;
      w0 = wr_count;
      exp_w = 0;
      panel_data = d;
      write_sw = (kind == 0 || kind == 3);
      case (kind)
         0: begin
            press(1'b1, 1'b0);
            m_mem[m_addr] = d;
            m_q = d;
            m_addr = (m_addr + 1) % DEPTH;
            exp_w = 1;
         end
         1: begin
            press(1'b1, 1'b0);
            m_q = m_mem[m_addr];
            m_addr = (m_addr + 1) % DEPTH;
         end
         2: begin
            press(1'b0, 1'b1);
            m_addr = 0;
         end
         default: begin
            press(1'b1, 1'b1);
            m_addr = 0;
         end
      endcase
      chk($sformatf("op%0d_panel_addr", kind), panel_addr, m_addr);
      chk($sformatf("op%0d_panel_q", kind), panel_q, m_q);
      chk($sformatf("op%0d_ram_writes", kind), wr_count - w0, exp_w);
   endtask

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              we;
      logic [ADDR_W-1:0] exp_addr;
      logic [DATA_W-1:0] exp_wdata;
      logic              exp_we;
   } run_vec_t;

   run_vec_t vecs [6];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0;
      int lat;
      vecs[0] = '{4'h5, 8'h3C, 1'b1, 4'h5, 8'h3C, 1'b1};
      vecs[1] = '{4'hA, 8'h5A, 1'b0, 4'hA, 8'h5A, 1'b0};
      vecs[2] = '{4'hF, 8'hFF, 1'b1, 4'hF, 8'hFF, 1'b1};
      vecs[3] = '{4'h0, 8'h00, 1'b1, 4'h0, 8'h00, 1'b1};
      vecs[4] = '{4'h3, 8'hC3, 1'b0, 4'h3, 8'hC3, 1'b0};
      vecs[5] = '{4'h9, 8'h81, 1'b1, 4'h9, 8'h81, 1'b1};
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_addr = 0;
      m_q = '0;

      clear_n = 1'b0; mode_prog = 1'b0; step = 1'b0; addr_clear = 1'b0;
      write_sw = 1'b0; panel_data = '0; cpu_addr = '0; cpu_wdata = '0;
      cpu_we = 1'b0; cpu_halted = 1'b0;
      repeat (3) cyc();
      chk("rst_cpu_halt", cpu_halt, 0);
      chk("rst_prog_active", prog_active, 0);
      chk("rst_panel_addr", panel_addr, 0);
      chk("rst_panel_q", panel_q, 0);
      chk("rst_ram_we", ram_we, 0);
      clear_n = 1'b1;
      cyc();

      // Run mode: CPU drives the RAM directly
      for (int i = 0; i < 6; i++) begin
         cpu_addr = vecs[i].addr;
         cpu_wdata = vecs[i].wdata;
         cpu_we = vecs[i].we;
         #1;
         chk($sformatf("run%0d_ram_addr", i), ram_addr, vecs[i].exp_addr);
         chk($sformatf("run%0d_ram_wdata", i), ram_wdata, vecs[i].exp_wdata);
         chk($sformatf("run%0d_ram_we", i), ram_we, vecs[i].exp_we);
         chk($sformatf("run%0d_cpu_halt", i), cpu_halt, 0);
         cyc();
         if (vecs[i].we) m_mem[vecs[i].addr] = vecs[i].wdata;
      end
      cpu_we = 1'b0;

      // Halt request abandoned before the CPU acknowledges
      mode_prog = 1'b1;
      repeat (3) cyc();
      chk("abort_cpu_halt_set", cpu_halt, 1);
      mode_prog = 1'b0;
      repeat (3) cyc();
      chk("abort_cpu_halt_clr", cpu_halt, 0);
      chk("abort_prog_active", prog_active, 0);

      // Halt with a delayed ack; panel steps before the ack are ignored
      mode_prog = 1'b1;
      repeat (3) cyc();
      chk("halt_cpu_halt", cpu_halt, 1);
      chk("halt_prog_active_pre", prog_active, 0);
      w0 = wr_count;
      write_sw = 1'b1;
      panel_data = 8'h55;
      press(1'b1, 1'b0);
      chk("halt_no_write", wr_count - w0, 0);
      chk("halt_panel_addr", panel_addr, 0);
      cpu_halted = 1'b1;
      chk("halt_prog_active_before_edge", prog_active, 0);
      cyc();
      chk("halt_prog_active", prog_active, 1);

      // Three writes, clear, three reads
      op(0, 8'h11);
      op(0, 8'h22);
      op(0, 8'h33);
      chk("wr3_panel_addr", panel_addr, 3);
      chk("wr3_ram", {ram[0], ram[1], ram[2]}, 24'h112233);
      op(2, 8'h00);
      op(1, 8'h00);
      chk("rd0", panel_q, 8'h11);
      op(1, 8'h00);
      chk("rd1", panel_q, 8'h22);
      op(1, 8'h00);
      chk("rd2", panel_q, 8'h33);

      // Address wrap, then step and clear together
      for (int i = 0; i < 12; i++) op(1, 8'h00);
      chk("wrap_pre_addr", panel_addr, 15);
      op(0, 8'hAA);
      chk("wrap_ram15", ram[15], 8'hAA);
      chk("wrap_addr", panel_addr, 0);
      op(0, 8'h5C);
      op(3, 8'hEE);

      // Randomised panel operations against the model
      for (int i = 0; i < 30; i++) op($urandom_range(0, 2), 8'($urandom));
      for (int i = 0; i < DEPTH; i++) chk($sformatf("ram_final[%0d]", i), ram[i], m_mem[i]);

      // Step-to-write latency, then reset while the write is in flight
      write_sw = 1'b1;
      panel_data = 8'h77;
      step = 1'b1;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         cyc();
         if (ram_we) begin
            lat = n;
            break;
         end
      end
      chk("step_latency", lat, 3);
      #2 clear_n = 1'b0;
      #1;
      chk("mid_rst_ram_we", ram_we, 0);
      chk("mid_rst_cpu_halt", cpu_halt, 0);
      chk("mid_rst_prog_active", prog_active, 0);
      chk("mid_rst_panel_addr", panel_addr, 0);
      chk("mid_rst_panel_q", panel_q, 0);
      m_addr = 0;
      m_q = '0;
      cyc();
      w0 = wr_count;
      clear_n = 1'b1;
      repeat (12) cyc();
      chk("held_step_no_write", wr_count - w0, 0);
      chk("held_step_prog_active", prog_active, 1);
      chk("held_step_panel_addr", panel_addr, 0);
      step = 1'b0;
      repeat (4) cyc();

      // Leave program mode: halt and ownership drop on the same edge
      mode_prog = 1'b0;
      repeat (2) cyc();
      chk("exit_prog_active_hold", prog_active, 1);
      cyc();
      chk("exit_cpu_halt", cpu_halt, 0);
      chk("exit_prog_active", prog_active, 0);
      cpu_halted = 1'b0;
      cpu_addr = 4'h6;
      cpu_wdata = 8'h99;
      cpu_we = 1'b1;
      #1;
      chk("exit_ram_addr", ram_addr, 4'h6);
      chk("exit_ram_we", ram_we, 1);
      cyc();
      cpu_we = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
